// File: rtl/mux_2to1.sv
// Parameterised 2:1 mux with a combinational and a registered output, plus a select-change monitor.
// Optional registered parity output par_q is enabled by defining MUX_2TO1_PARITY_EN.
module mux_2to1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             s0,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_chg,
    output logic [CNT_W-1:0] sw_cnt
`ifdef MUX_2TO1_PARITY_EN
    ,
    output logic             par_q
`endif
);

    logic [WIDTH-1:0] out_qr;
    logic             s0_last_q;
    logic             primed_q;
    logic             sel_chg_q;
    logic [CNT_W-1:0] sw_cnt_q;
    logic [CNT_W-1:0] sw_cnt_d;
    logic             chg_d;

    // Continuous assignment keeps X/Z on s0 visible at the output.
    assign out = s0 ? in1 : in0;

    assign chg_d = primed_q & (s0 != s0_last_q);

    always_comb begin
        sw_cnt_d = sw_cnt_q;
        if (chg_d && (sw_cnt_q != {CNT_W{1'b1}}))
            sw_cnt_d = sw_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_qr    <= '0;
            s0_last_q <= 1'b0;
            primed_q  <= 1'b0;
            sel_chg_q <= 1'b0;
            sw_cnt_q  <= '0;
        end else begin
            out_qr    <= s0 ? in1 : in0;
            s0_last_q <= s0;
            primed_q  <= 1'b1;
            sel_chg_q <= chg_d;
            sw_cnt_q  <= sw_cnt_d;
        end
    end

    assign out_q   = out_qr;
    assign sel_chg = sel_chg_q;
    assign sw_cnt  = sw_cnt_q;

`ifdef MUX_2TO1_PARITY_EN
    logic par_qr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_qr <= 1'b0;
        else        par_qr <= ^(s0 ? in1 : in0);
    end

    assign par_q = par_qr;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: a WIDTH=1/CNT_W=8 instance and a WIDTH=8/CNT_W=2 instance.
module tb_mux_2to1;

    logic       clk;
    logic       rst_n;
    logic       a_in0, a_in1, a_s0;
    logic       a_out, a_out_q, a_chg;
    logic [7:0] a_cnt;
    logic [7:0] b_in0, b_in1;
    logic       b_s0;
    logic [7:0] b_out, b_out_q;
    logic       b_chg;
    logic [1:0] b_cnt;
`ifdef MUX_2TO1_PARITY_EN
    logic       a_par, b_par;
`endif

    int tests = 0;
    int fails = 0;
    int exp_cnt[6] = '{1, 2, 3, 3, 3, 3};

    mux_2to1 #(.WIDTH(1), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in0(a_in0), .in1(a_in1), .s0(a_s0),
        .out(a_out), .out_q(a_out_q), .sel_chg(a_chg), .sw_cnt(a_cnt)
`ifdef MUX_2TO1_PARITY_EN
        , .par_q(a_par)
`endif
    );

    mux_2to1 #(.WIDTH(8), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in0(b_in0), .in1(b_in1), .s0(b_s0),
        .out(b_out), .out_q(b_out_q), .sel_chg(b_chg), .sw_cnt(b_cnt)
`ifdef MUX_2TO1_PARITY_EN
        , .par_q(b_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_in0 = 1'b0; a_in1 = 1'b1; a_s0 = 1'b1;
        b_in0 = 8'h00; b_in1 = 8'h00; b_s0 = 1'b0;
        #1;
        chk("rst_a_out_q", a_out_q, 0);
        chk("rst_a_chg", a_chg, 0);
        chk("rst_a_cnt", a_cnt, 0);
        chk("rst_b_out_q", b_out_q, 0);
        chk("rst_b_cnt", b_cnt, 0);
        chk("rst_a_out_comb", a_out, 1);
        tick(); tick();
        rst_n = 1'b1;

        // Basic mux function on the 1-bit instance
        #100;
        chk("a_out_s1", a_out, 1);
        tick();
        chk("a_out_q_s1", a_out_q, 1);
        chk("a_cnt_hold", a_cnt, 0);
        a_s0 = 1'b0;
        #100;
        chk("a_out_s0", a_out, 0);
        tick();
        chk("a_out_q_s0", a_out_q, 0);
        chk("a_cnt_1", a_cnt, 1);

        // Build up out_q=1, sw_cnt=3
        a_in0 = 1'b1;
        a_s0 = 1'b1; tick();
        chk("a_cnt_2", a_cnt, 2);
        a_s0 = 1'b0; tick();
        chk("a_cnt_3", a_cnt, 3);
        chk("a_out_q_pre_rst", a_out_q, 1);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_q", a_out_q, 0);
        chk("arst_chg", a_chg, 0);
        chk("arst_cnt", a_cnt, 0);
        a_in1 = 1'b0; a_s0 = 1'b1;
        #1;
        chk("arst_out_track0", a_out, 0);
        a_in1 = 1'b1;
        #1;
        chk("arst_out_track1", a_out, 1);
        tick();
        chk("arst_held_out_q", a_out_q, 0);

        // Release with s0=1: first edge never flags a change
        rst_n = 1'b1;
        tick();
        chk("rel_first_chg", a_chg, 0);
        chk("rel_first_cnt", a_cnt, 0);
        a_s0 = 1'b0; tick();
        chk("rel_chg", a_chg, 1);
        chk("rel_cnt", a_cnt, 1);
        tick();
        chk("rel_chg_drop", a_chg, 0);
        chk("rel_cnt_hold", a_cnt, 1);

        // Glitch on s0 between edges is invisible to the monitor
        b_in0 = 8'hA5; b_in1 = 8'h3C;
        tick();
        chk("b_out_q_a5", b_out_q, 8'hA5);
        #2; b_s0 = 1'b1;
        #1; chk("b_out_glitch", b_out, 8'h3C);
        #1; b_s0 = 1'b0;
        tick();
        chk("glitch_chg", b_chg, 0);
        chk("glitch_cnt", b_cnt, 0);
        chk("glitch_out_q", b_out_q, 8'hA5);

        // Saturating counter with CNT_W=2
        for (int i = 0; i < 6; i++) begin
            b_s0 = ~b_s0;
            tick();
            chk($sformatf("sat_cnt_%0d", i), b_cnt, exp_cnt[i]);
            chk($sformatf("sat_chg_%0d", i), b_chg, 1);
        end
        chk("sat_out_q", b_out_q, 8'hA5);

`ifdef MUX_2TO1_PARITY_EN
        b_s0 = 1'b1; b_in1 = 8'h07;
        tick();
        chk("par_07", b_par, 1);
        b_s0 = 1'b0; b_in0 = 8'h03;
        tick();
        chk("par_03", b_par, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_2to1.md
Name: mux_2to1

Overview:
- Parameterised 2:1 data multiplexer with a combinational output and a registered output.
- Select-activity monitor: a change pulse and a saturating switch counter.
- Used as a basic datapath steering element. Also serves as the reference leaf cell for combinational/registered mux checks.

Parameters:
- WIDTH, 1, data width of in0, in1, out and out_q (minimum 1).
- CNT_W, 8, width of the select-switch counter sw_cnt (minimum 1).

Ports:
- clk  input  1  single clock; all registers update on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in0  input  WIDTH  data input, chosen when s0=0.
- in1  input  WIDTH  data input, chosen when s0=1.
- s0  input  1  select line.
- out  output  WIDTH  combinational mux output.
- out_q  output  WIDTH  registered mux output.
- sel_chg  output  1  registered one-cycle pulse when s0 changed since the previous sampled edge.
- sw_cnt  output  CNT_W  saturating count of detected select changes.
- Interface rule: one clock; reset is asynchronous and active-low.

Behaviour:
- out = s0 ? in1 : in0.
  - Purely combinational, zero latency, independent of clk and rst_n.
  - Valid during reset.
  - X/Z on s0 must not be masked: out follows normal continuous-assignment semantics.
- out_q:
  - Captures (s0 ? in1 : in0) on each rising clk edge.
  - Latency is 1 cycle.
  - Reset value is all zeros.
- Select history:
  - Internal register s0_d holds s0 sampled at the last edge.
  - Internal flag primed is 0 in reset and becomes 1 at the first edge after reset release.
  - s0_d resets to 0.
- sel_chg:
  - At each edge, sel_chg <= primed & (s0 != s0_d). Then s0_d <= s0 and primed <= 1.
  - The first edge after reset never asserts sel_chg, whatever the value of s0.
  - Reset value is 0.
  - If s0 toggles between two edges and returns to its original value, no change is detected (edge-sampled only).
- sw_cnt:
  - Increments by 1 on each edge where a change is detected (same condition as sel_chg), in the same cycle sel_chg is set.
  - Saturates at 2^CNT_W-1; there is no wrap-around.
  - Reset value is 0.
- Reset asserted mid-operation: out_q, sel_chg, sw_cnt, s0_d and primed clear immediately, without waiting for clk.
- Reset release: registers resume on the next rising edge. Deassertion is assumed synchronised externally.
- No handshake, no enable: every clock edge is active.

Optional Feature:
- Macro: MUX_2TO1_PARITY_EN.
- When defined:
  - Extra output port par_q (1 bit) is added.
  - par_q is registered even parity (XOR reduction) of the selected data, updated alongside out_q with the same 1-cycle latency.
  - par_q resets to 0.
- When undefined: port par_q and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=1; in1=1, in0=0, s0=1, hold 100 ns -> out=1; after the next edge out_q=1. Then s0=0, hold 100 ns -> out=0; after the next edge out_q=0.
- Assert rst_n=0 mid-run with out_q=1, sw_cnt=3 -> out_q=0, sel_chg=0, sw_cnt=0 immediately, before any clk edge; out keeps tracking its inputs.
- After reset release with s0=1 at the first edge -> sel_chg=0, sw_cnt=0. Toggle s0 to 0 -> next edge sel_chg=1, sw_cnt=1. Hold s0 -> sel_chg back to 0 one cycle later.
- CNT_W=2; toggle s0 every cycle for 6 cycles -> sw_cnt goes 1,2,3,3,3,3 (saturated); sel_chg stays 1 each cycle.
- WIDTH=8; in0=8'hA5, in1=8'h3C; s0 pulses high and low between two edges -> no sel_chg, sw_cnt unchanged, out_q=8'hA5.
- With MUX_2TO1_PARITY_EN defined, WIDTH=8: s0=1, in1=8'h07 -> par_q=1 after one edge; s0=0, in0=8'h03 -> par_q=0.
